// File: rtl/codec_reg_sequencer_if.sv
// Request/status and I2C byte-engine signals of the WM8731 register sequencer.
// master = sequencer side, slave = user control plus I2C engine side.
interface codec_reg_sequencer_if;
  logic        vol_req;
  logic [6:0]  vol_value;
  logic        mute_req;
  logic        mute_value;
  logic        i2c_start;
  logic [23:0] i2c_data;
  logic        i2c_done;
  logic        i2c_ack;
  logic        init_done;
  logic        busy;
  logic        error;

  modport master (
    input  vol_req, vol_value, mute_req, mute_value, i2c_done, i2c_ack,
    output i2c_start, i2c_data, init_done, busy, error
  );
  modport slave (
    output vol_req, vol_value, mute_req, mute_value, i2c_done, i2c_ack,
    input  i2c_start, i2c_data, init_done, busy, error
  );
endinterface

// File: rtl/codec_reg_sequencer.sv
// Plays the WM8731 init table over a shared I2C engine, then serves runtime
// volume/mute writes with retry on NACK/timeout and a sticky error flag.
module codec_reg_sequencer #(
  parameter int         RETRIES        = 3,
  parameter int         GAP_CYCLES     = 500,
  parameter int         TIMEOUT_CYCLES = 50000,
  parameter logic [6:0] DEFAULT_VOL    = 7'h79
) (
  input  logic                  clock,
  input  logic                  reset,
  codec_reg_sequencer_if.master bus
);
  localparam int CMAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int AW   = $clog2(RETRIES + 1);
  localparam logic [7:0] DEV = 8'h34;

  typedef enum logic [2:0] {BOOT, ISSUE, WAIT, GAP, IDLE, HALT} state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [AW-1:0] attempt, attempt_d;
  logic [3:0]    idx, idx_d;
  logic          vol_pend, vol_pend_d, mute_pend, mute_pend_d;
  logic [6:0]    vol_val, vol_val_d;
  logic          mute_val, mute_val_d;
  logic          start_q, start_d, init_q, init_d, busy_q, busy_d, err_q, err_d;
  logic [23:0]   data_q, data_d;
  logic          fail;
  logic [AW-1:0] attempt_nx;

  function automatic logic [15:0] init_word(input logic [3:0] i);
    case (i)
      4'd0:    init_word = {7'd15, 9'h000};
      4'd1:    init_word = {7'd6,  9'h000};
      4'd2:    init_word = {7'd0,  9'h017};
      4'd3:    init_word = {7'd1,  9'h017};
      4'd4:    init_word = {7'd2,  2'b10, DEFAULT_VOL};
      4'd5:    init_word = {7'd4,  9'h012};
      4'd6:    init_word = {7'd5,  9'h000};
      4'd7:    init_word = {7'd7,  9'h042};
      4'd8:    init_word = {7'd8,  9'h000};
      default: init_word = {7'd9,  9'h001};
    endcase
  endfunction

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    attempt_d   = attempt;
    idx_d       = idx;
    vol_pend_d  = vol_pend;
    vol_val_d   = vol_val;
    mute_pend_d = mute_pend;
    mute_val_d  = mute_val;
    start_d     = 1'b0;
    data_d      = data_q;
    init_d      = init_q;
    err_d       = err_q;
    fail        = 1'b0;
    attempt_nx  = AW'(attempt + 1'b1);
    case (state)
      BOOT: state_d = ISSUE;
      ISSUE: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT;
        // a retry resends the word already held on i2c_data
        if (attempt == '0) begin
          if (!init_q) begin
            data_d = {DEV, init_word(idx)};
          end else if (mute_pend) begin
            data_d      = {DEV, 7'd5, 5'b0, mute_val, 3'b000};
            mute_pend_d = 1'b0;
          end else begin
            data_d     = {DEV, 7'd2, 2'b10, vol_val};
            vol_pend_d = 1'b0;
          end
        end
      end
      WAIT: begin
        if (bus.i2c_done) begin
          cnt_d   = '0;
          state_d = GAP;
          if (bus.i2c_ack) begin
            attempt_d = '0;
            if (!init_q) idx_d = 4'(idx + 1'b1);
          end else begin
            fail = 1'b1;
          end
        end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          fail = 1'b1;
        end else begin
          cnt_d = CW'(cnt + 1'b1);
        end
        if (fail) begin
          cnt_d = '0;
          if (int'(attempt_nx) < RETRIES) begin
            attempt_d = attempt_nx;
            state_d   = GAP;
          end else if (!init_q) begin
            err_d   = 1'b1;
            state_d = HALT;
          end else begin
            err_d     = 1'b1;
            attempt_d = '0;
            state_d   = GAP;
          end
        end
      end
      GAP: begin
        // the ISSUE cycle is the last idle clock, so GAP itself runs GAP_CYCLES-1
        if (cnt == CW'(GAP_CYCLES - 2)) begin
          cnt_d = '0;
          if (!init_q) begin
            if (idx == 4'd10) begin
              init_d  = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = ISSUE;
            end
          end else begin
            state_d = (attempt != '0 || mute_pend || vol_pend) ? ISSUE : IDLE;
          end
        end else begin
          cnt_d = CW'(cnt + 1'b1);
        end
      end
      IDLE: if (mute_pend || vol_pend) state_d = ISSUE;
      default: state_d = HALT;
    endcase
    // a strobe in the ISSUE cycle re-arms the flag just cleared above
    if (state != HALT) begin
      if (bus.vol_req) begin
        vol_pend_d = 1'b1;
        vol_val_d  = bus.vol_value;
      end
      if (bus.mute_req) begin
        mute_pend_d = 1'b1;
        mute_val_d  = bus.mute_value;
      end
    end
    busy_d = !(state_d == IDLE && !mute_pend_d && !vol_pend_d);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= BOOT;
      cnt       <= '0;
      attempt   <= '0;
      idx       <= '0;
      vol_pend  <= 1'b0;
      vol_val   <= '0;
      mute_pend <= 1'b0;
      mute_val  <= 1'b0;
      start_q   <= 1'b0;
      data_q    <= '0;
      init_q    <= 1'b0;
      busy_q    <= 1'b1;
      err_q     <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      attempt   <= attempt_d;
      idx       <= idx_d;
      vol_pend  <= vol_pend_d;
      vol_val   <= vol_val_d;
      mute_pend <= mute_pend_d;
      mute_val  <= mute_val_d;
      start_q   <= start_d;
      data_q    <= data_d;
      init_q    <= init_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign bus.i2c_start = start_q;
  assign bus.i2c_data  = data_q;
  assign bus.init_done = init_q;
  assign bus.busy      = busy_q;
  assign bus.error     = err_q;
endmodule

// File: tb/tb_codec_reg_sequencer.sv
// Directed bench for codec_reg_sequencer: boot table, retries, timeouts/HALT,
// pending-request arbitration and the ISSUE-cycle strobe collision.
module tb_codec_reg_sequencer;
  localparam int GAP   = 20;
  localparam int TMO   = 300;
  localparam int DELAY = 100;

  logic clock = 1'b0;
  logic reset;
  codec_reg_sequencer_if bus ();

  codec_reg_sequencer #(
    .RETRIES(3), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .DEFAULT_VOL(7'h79)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #10 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // expected init words {8'h34, reg[6:0], data[8:0]}
  logic [23:0] exp_init [10] = '{24'h341E00, 24'h340C00, 24'h340017, 24'h340217, 24'h340579,
                                 24'h340812, 24'h340A00, 24'h340E42, 24'h341000, 24'h341201};

  // I2C engine model and start monitor
  int          cyc = 0;
  int          last_done_cyc = 0;
  int          init_cyc = -1;
  int          eng_cnt = 0;
  bit          eng_ack;
  logic [23:0] eng_data;
  logic [23:0] nack_word = '0;
  int          nack_left = 0;
  bit          silent_en = 1'b0;
  logic [23:0] silent_word = '0;
  logic [23:0] words [$];
  int          start_cyc [$];
  int          gap_q [$];

  initial begin
    bus.i2c_done = 1'b0;
    bus.i2c_ack  = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      bus.i2c_done = 1'b0;
      bus.i2c_ack  = 1'b0;
      if (reset !== 1'b0) begin
        eng_cnt = 0;
      end else begin
        if (bus.init_done === 1'b1 && init_cyc < 0) init_cyc = cyc;
        if (eng_cnt > 0) begin
          eng_cnt--;
          if (eng_cnt == 0) begin
            tests++;
            if (bus.i2c_data !== eng_data) begin
              fails++;
              $display("FAIL data_hold: i2c_data %h at done, launched with %h", bus.i2c_data, eng_data);
            end
            bus.i2c_done  = 1'b1;
            bus.i2c_ack   = eng_ack;
            last_done_cyc = cyc;
          end
        end else if (bus.i2c_start === 1'b1) begin
          words.push_back(bus.i2c_data);
          start_cyc.push_back(cyc);
          gap_q.push_back(cyc - last_done_cyc);
          eng_data = bus.i2c_data;
          if (!(silent_en && bus.i2c_data == silent_word)) begin
            eng_ack = !(nack_left > 0 && bus.i2c_data == nack_word);
            if (!eng_ack) nack_left--;
            eng_cnt = DELAY;
          end
        end
      end
    end
  end

  task automatic tick;
    @(negedge clock);
    #1;
  endtask

  task automatic do_reset(input logic [23:0] nw, input int nn, input bit se, input logic [23:0] sw);
    reset = 1'b1;
    bus.vol_req  = 1'b0;
    bus.mute_req = 1'b0;
    repeat (3) tick;
    words.delete();
    start_cyc.delete();
    gap_q.delete();
    init_cyc      = -1;
    last_done_cyc = 0;
    nack_word     = nw;
    nack_left     = nn;
    silent_en     = se;
    silent_word   = sw;
    reset = 1'b0;
  endtask

  // sel 0: init_done, 1: not busy, 2: error
  task automatic wait_cond(input int sel, input int bound, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < bound && !hit; i++) begin
      tick;
      case (sel)
        0:       hit = (bus.init_done === 1'b1);
        1:       hit = (bus.busy === 1'b0);
        default: hit = (bus.error === 1'b1);
      endcase
    end
    tests++;
    if (!hit) begin
      fails++;
      $display("FAIL %s: not reached within %0d cycles", name, bound);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  task automatic strobe_vol(input logic [6:0] v);
    tick;
    bus.vol_req = 1'b1;
    bus.vol_value = v;
    tick;
    bus.vol_req = 1'b0;
  endtask

  task automatic strobe_mute(input logic m);
    tick;
    bus.mute_req = 1'b1;
    bus.mute_value = m;
    tick;
    bus.mute_req = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.vol_req = 1'b0; bus.vol_value = '0; bus.mute_req = 1'b0; bus.mute_value = 1'b0;
    repeat (3) tick;
    chk("rst_start", 32'(bus.i2c_start), 32'd0);
    chk("rst_data", 32'(bus.i2c_data), 32'd0);
    chk("rst_init_done", 32'(bus.init_done), 32'd0);
    chk("rst_error", 32'(bus.error), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    tick;
    chk("first_clk_no_start", 32'(bus.i2c_start), 32'd0);
    tick;
    chk("second_clk_start", 32'(bus.i2c_start), 32'd1);
    chk("second_clk_data", 32'(bus.i2c_data), 32'h341E00);
  endtask

  task automatic test_boot;
    wait_cond(0, 3000, "boot_init_done");
    chk("boot_starts", 32'(words.size()), 32'd10);
    for (int i = 0; i < 10 && i < words.size(); i++) begin
      chk($sformatf("boot_word%0d", i), 32'(words[i]), 32'(exp_init[i]));
      if (i > 0) chk($sformatf("boot_gap%0d", i), 32'(gap_q[i]), 32'(GAP + 1));
    end
    chk("init_done_after_gap", 32'(init_cyc - last_done_cyc), 32'(GAP));
    tick;
    chk("boot_busy", 32'(bus.busy), 32'd0);
    chk("boot_error", 32'(bus.error), 32'd0);
  endtask

  task automatic test_issue_collision;
    int base = words.size();
    chk("idle_busy_low", 32'(bus.busy), 32'd0);
    tick;
    bus.vol_req = 1'b1; bus.vol_value = 7'h30;
    tick;
    bus.vol_req = 1'b0;
    chk("busy_after_strobe", 32'(bus.busy), 32'd1);
    tick;                                   // sequencer sits in ISSUE this cycle
    bus.vol_req = 1'b1; bus.vol_value = 7'h40;
    tick;
    bus.vol_req = 1'b0;
    chk("coll_start", 32'(bus.i2c_start), 32'd1);
    chk("coll_first_data", 32'(bus.i2c_data), 32'h340530);
    wait_cond(1, 1000, "coll_drain");
    chk("coll_starts", 32'(words.size() - base), 32'd2);
    if (words.size() >= base + 2) begin
      chk("coll_word0", 32'(words[base]), 32'h340530);
      chk("coll_word1", 32'(words[base+1]), 32'h340540);
      chk("coll_gap", 32'(gap_q[base+1]), 32'(GAP + 1));
    end
  endtask

  task automatic test_runtime_nack;
    int base = words.size();
    nack_word = 24'h340520;
    nack_left = 3;
    strobe_vol(7'h20);
    wait_cond(2, 2000, "rt_error");
    chk("rt_error", 32'(bus.error), 32'd1);
    chk("rt_init_done", 32'(bus.init_done), 32'd1);
    wait_cond(1, 1000, "rt_drain");
    chk("rt_attempts", 32'(words.size() - base), 32'd3);
    for (int i = base; i < base + 3 && i < words.size(); i++)
      chk($sformatf("rt_word%0d", i - base), 32'(words[i]), 32'h340520);
    strobe_mute(1'b0);
    wait_cond(1, 1000, "rt_mute_drain");
    chk("rt_mute_served", 32'(words.size() - base), 32'd4);
    if (words.size() >= base + 4) chk("rt_mute_word", 32'(words[base+3]), 32'h340A00);
    chk("rt_error_sticky", 32'(bus.error), 32'd1);
  endtask

  task automatic test_reset_mid;
    do_reset('0, 0, 1'b0, '0);
    for (int i = 0; i < 500 && words.size() < 2; i++) tick;
    repeat (10) tick;
    chk("mid_pre_data", 32'(bus.i2c_data), 32'h340C00);
    reset = 1'b1;
    #1;
    chk("mid_data_clr", 32'(bus.i2c_data), 32'd0);
    chk("mid_busy", 32'(bus.busy), 32'd1);
    chk("mid_init_done", 32'(bus.init_done), 32'd0);
  endtask

  task automatic test_nack_retry;
    do_reset(exp_init[3], 2, 1'b0, '0);
    chk("rst_clears_error", 32'(bus.error), 32'd0);
    wait_cond(0, 4000, "nack_init_done");
    chk("nack_starts", 32'(words.size()), 32'd12);
    if (words.size() >= 12) begin
      for (int i = 3; i < 6; i++) chk($sformatf("nack_retry%0d", i - 3), 32'(words[i]), 32'(exp_init[3]));
      chk("nack_next_entry", 32'(words[6]), 32'(exp_init[4]));
      chk("nack_last_entry", 32'(words[11]), 32'(exp_init[9]));
    end
    chk("nack_error", 32'(bus.error), 32'd0);
  endtask

  task automatic test_init_strobes;
    do_reset('0, 0, 1'b0, '0);
    repeat (300) tick;
    strobe_vol(7'h50);
    repeat (40) tick;
    strobe_mute(1'b1);
    repeat (40) tick;
    strobe_vol(7'h60);
    chk("init_strobe_no_done", 32'(bus.init_done), 32'd0);
    wait_cond(0, 3000, "strobe_init_done");
    wait_cond(1, 1000, "strobe_drain");
    chk("strobe_starts", 32'(words.size()), 32'd12);
    if (words.size() >= 12) begin
      chk("strobe_mute_first", 32'(words[10]), 32'h340A08);
      chk("strobe_vol_latest", 32'(words[11]), 32'h340560);
      chk("strobe_first_gap", 32'(gap_q[10]), 32'(GAP + 2));
    end
  endtask

  task automatic test_timeout_halt;
    do_reset('0, 0, 1'b1, exp_init[5]);
    wait_cond(2, 3000, "tmo_error");
    chk("tmo_starts", 32'(words.size()), 32'd8);
    if (words.size() >= 8) begin
      for (int i = 5; i < 8; i++) chk($sformatf("tmo_word%0d", i - 5), 32'(words[i]), 32'(exp_init[5]));
      chk("tmo_spacing", 32'(start_cyc[6] - start_cyc[5]), 32'(TMO + GAP));
    end
    chk("tmo_init_done", 32'(bus.init_done), 32'd0);
    chk("tmo_busy", 32'(bus.busy), 32'd1);
    strobe_vol(7'h11);
    repeat (500) tick;
    chk("halt_no_start", 32'(words.size()), 32'd8);
    chk("halt_error", 32'(bus.error), 32'd1);
  endtask

  initial begin
    test_reset;
    test_boot;
    test_issue_collision;
    test_runtime_nack;
    test_reset_mid;
    test_nack_retry;
    test_init_strobes;
    test_timeout_halt;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
